// File: rtl/keypad_scan_pulse.sv
// rtl/keypad_scan_pulse.sv - 4x4 keypad scanner with debounced single-cycle key pulse
// Each accepted press yields one {valid, row*4+col} pulse; a debounced release re-arms the scan.
module keypad_scan_pulse #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [4:0] pulse,
    output logic       key_held
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DBC_DONE  = DW'(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DBC_ONE   = DW'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_WAIT_RELEASE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [3:0]    row_s1;
    logic [3:0]    row_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [1:0]    col_idx;
    logic [1:0]    col_idx_n;
    logic [1:0]    row_idx;
    logic [1:0]    row_idx_n;
    logic [DW-1:0] dbc;
    logic [DW-1:0] dbc_n;
    logic [DW-1:0] dbc_inc;
    logic [4:0]    pulse_n;
    logic          key_held_n;
    logic          sample_valid;
    logic [1:0]    sample_row;
    logic          no_key;

    // row_in is asynchronous to clock; only the second stage feeds the decode
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_s1   <= 4'hF;
            row_s    <= 4'hF;
            tick_cnt <= '0;
        end else begin
            row_s1   <= row_in;
            row_s    <= row_s1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Exactly one row low is a usable sample; multiple lows are ghosting and count as no key
    always_comb begin
        sample_valid = 1'b1;
        sample_row   = 2'd0;
        case (row_s)
            4'b1110: sample_row = 2'd0;
            4'b1101: sample_row = 2'd1;
            4'b1011: sample_row = 2'd2;
            4'b0111: sample_row = 2'd3;
            default: sample_valid = 1'b0;
        endcase
    end

    assign no_key = (row_s == 4'hF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_SCAN;
            col_idx  <= 2'd0;
            row_idx  <= 2'd0;
            dbc      <= '0;
            pulse    <= 5'b0;
            key_held <= 1'b0;
        end else begin
            state    <= state_n;
            col_idx  <= col_idx_n;
            row_idx  <= row_idx_n;
            dbc      <= dbc_n;
            pulse    <= pulse_n;
            key_held <= key_held_n;
        end
    end

    always_comb begin
        state_n    = state;
        col_idx_n  = col_idx;
        row_idx_n  = row_idx;
        dbc_n      = dbc;
        pulse_n    = 5'b0;
        key_held_n = key_held;
        dbc_inc    = dbc + 1'b1;

        case (state)
            ST_SCAN: begin
                if (tick) begin
                    if (sample_valid) begin
                        row_idx_n = sample_row;
                        if (DBC_DONE == DBC_ONE) begin
                            dbc_n   = '0;
                            state_n = ST_EMIT;
                        end else begin
                            dbc_n   = DBC_ONE;
                            state_n = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_n = col_idx + 1'b1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (sample_valid && (sample_row == row_idx)) begin
                        dbc_n = dbc_inc;
                        if (dbc_inc == DBC_DONE) begin
                            state_n = ST_EMIT;
                        end
                    end else begin
                        dbc_n     = '0;
                        col_idx_n = col_idx + 1'b1;
                        state_n   = ST_SCAN;
                    end
                end
            end
            ST_EMIT: begin
                dbc_n      = '0;
                key_held_n = 1'b1;
                state_n    = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                key_held_n = 1'b1;
                if (tick) begin
                    if (no_key) begin
                        if (dbc_inc == DBC_DONE) begin
                            key_held_n = 1'b0;
                            dbc_n      = '0;
                            col_idx_n  = col_idx + 1'b1;
                            state_n    = ST_SCAN;
                        end else begin
                            dbc_n = dbc_inc;
                        end
                    end else begin
                        dbc_n = '0;
                    end
                end
            end
            default: begin
                state_n = ST_SCAN;
            end
        endcase

        // Load the pulse on the way into EMIT so it is visible during the EMIT cycle itself
        if (state_n == ST_EMIT) begin
            pulse_n    = {1'b1, row_idx_n, col_idx_n};
            key_held_n = 1'b1;
        end
    end

    assign col_out = ~(4'b0001 << col_idx);

endmodule

// File: tb/tb_keypad_scan_pulse.sv
// tb/tb_keypad_scan_pulse.sv - directed bench for keypad_scan_pulse
// A keypad model pulls a row low only while its column is driven; force_* overrides it for glitches.
module tb_keypad_scan_pulse;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [4:0] pulse;
    logic       key_held;

    logic       key_down  = 1'b0;
    logic [1:0] key_row   = 2'd0;
    logic [1:0] key_col   = 2'd0;
    logic       force_en  = 1'b0;
    logic [3:0] force_val = 4'hF;

    int n_checks   = 0;
    int n_fail     = 0;
    int pulse_cnt  = 0;
    int stray_code = 0;

    keypad_scan_pulse #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .pulse    (pulse),
        .key_held (key_held)
    );

    always #5 clock = ~clock;

    assign row_in = force_en ? force_val :
                    (key_down && (col_out[key_col] == 1'b0)) ? ~(4'b0001 << key_row) : 4'hF;

    always @(negedge clock) begin
        if (pulse[4]) pulse_cnt++;
        if (!pulse[4] && (pulse[3:0] != 4'h0)) stray_code++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_col(input logic [3:0] target, output bit ok);
        int n;
        n = 0;
        while ((col_out == target) && (n < 200)) begin
            @(negedge clock);
            n++;
        end
        while ((col_out != target) && (n < 200)) begin
            @(negedge clock);
            n++;
        end
        ok = (col_out == target) && (n < 200);
    endtask

    task automatic wait_pulse(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; (i < limit) && !ok; i++) begin
            @(negedge clock);
            if (pulse[4]) ok = 1'b1;
        end
    endtask

    task automatic wait_released(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; (i < limit) && !ok; i++) begin
            @(negedge clock);
            if (!key_held) ok = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit seen;

        // 1: reset state and free-running column scan
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_col", col_out, 4'b1110);
        check("rst_pulse", pulse, 5'b0);
        check("rst_held", key_held, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("scan_c0_hold", col_out, 4'b1110);
        @(negedge clock);
        check("scan_c1", col_out, 4'b1101);
        repeat (4) @(negedge clock);
        check("scan_c2", col_out, 4'b1011);
        repeat (4) @(negedge clock);
        check("scan_c3", col_out, 4'b0111);
        repeat (4) @(negedge clock);
        check("scan_wrap", col_out, 4'b1110);

        // 2: held key (row 1, col 2) gives exactly one pulse
        key_row = 2'd1; key_col = 2'd2; key_down = 1'b1;
        wait_pulse(100, ok);
        check("t2_pulse_seen", ok, 1'b1);
        check("t2_pulse_val", pulse, 5'b1_0110);
        check("t2_held", key_held, 1'b1);
        check("t2_col_frozen", col_out, 4'b1011);
        @(negedge clock);
        check("t2_pulse_one_clk", pulse, 5'b0);
        repeat (100) @(negedge clock);
        #1;
        check("t2_no_repeat", pulse_cnt, 1);
        check("t2_held_long", key_held, 1'b1);
        check("t2_col_long", col_out, 4'b1011);
        key_down = 1'b0;
        wait_released(100, ok);
        check("t2_release", ok, 1'b1);

        // 3: single-tick bounce on row 1 / col 2
        wait_col(4'b1011, ok);
        check("t3_reach_c2", ok, 1'b1);
        force_val = 4'b1101; force_en = 1'b1;
        repeat (4) @(negedge clock);
        check("t3_col_held", col_out, 4'b1011);
        force_en = 1'b0; force_val = 4'hF;
        repeat (4) @(negedge clock);
        check("t3_resume_c3", col_out, 4'b0111);
        repeat (20) @(negedge clock);
        #1;
        check("t3_no_pulse", pulse_cnt, 1);

        // 4: two rows low together is ghosting, scan keeps moving
        force_val = 4'b1010; force_en = 1'b1;
        wait_col(4'b1110, ok);
        check("t4_reach_c0", ok, 1'b1);
        repeat (4) @(negedge clock);
        check("t4_c1", col_out, 4'b1101);
        repeat (4) @(negedge clock);
        check("t4_c2", col_out, 4'b1011);
        repeat (4) @(negedge clock);
        check("t4_c3", col_out, 4'b0111);
        #1;
        check("t4_no_pulse", pulse_cnt, 1);
        check("t4_not_held", key_held, 1'b0);
        force_en = 1'b0; force_val = 4'hF;

        // 5: key F, release with one glitch tick, then re-press
        key_row = 2'd3; key_col = 2'd3; key_down = 1'b1;
        wait_pulse(100, ok);
        check("t5_pulse1_seen", ok, 1'b1);
        check("t5_pulse1_val", pulse, 5'b1_1111);
        key_down = 1'b0;
        repeat (4) @(negedge clock);
        key_down = 1'b1;
        repeat (4) @(negedge clock);
        key_down = 1'b0;
        check("t5_held_after_glitch", key_held, 1'b1);
        repeat (4) @(negedge clock);
        check("t5_held_one_high", key_held, 1'b1);
        repeat (4) @(negedge clock);
        check("t5_released_two_high", key_held, 1'b0);
        #1;
        check("t5_one_so_far", pulse_cnt, 2);
        key_down = 1'b1;
        wait_pulse(100, ok);
        check("t5_pulse2_seen", ok, 1'b1);
        check("t5_pulse2_val", pulse, 5'b1_1111);
        #1;
        check("t5_two_pulses", pulse_cnt, 3);
        key_down = 1'b0;
        wait_released(100, ok);
        check("t5_final_release", ok, 1'b1);

        // 6: reset in DEBOUNCE aborts the press; debounce restarts from scratch
        wait_col(4'b1101, ok);
        check("t6_reach_c1", ok, 1'b1);
        key_row = 2'd0; key_col = 2'd1; key_down = 1'b1;
        repeat (4) @(negedge clock);
        check("t6_in_debounce", col_out, 4'b1101);
        reset = 1'b1;
        #1;
        check("t6_rst_col", col_out, 4'b1110);
        check("t6_rst_pulse", pulse, 5'b0);
        check("t6_rst_held", key_held, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (11) begin
            @(negedge clock);
            if (pulse[4]) seen = 1'b1;
        end
        check("t6_no_early_pulse", seen, 1'b0);
        @(negedge clock);
        check("t6_pulse_val", pulse, 5'b1_0001);
        @(negedge clock);
        #1;
        check("t6_pulse_total", pulse_cnt, 4);
        key_down = 1'b0;
        wait_released(100, ok);
        check("t6_release", ok, 1'b1);

        check("code_zero_when_invalid", stray_code, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
